// File: rtl/float_adder_arbiter_if.sv
// Requester, response and adder-side signals of float_adder_arbiter.
// slave: the arbiter's view; master: the requester/consumer/adder side.
interface float_adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [32*N_REQ-1:0] req_a_i;
  logic [32*N_REQ-1:0] req_b_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [31:0]         rsp_sum_o;
  logic [ID_W-1:0]     rsp_id_o;
  logic                fa_start_o;
  logic [31:0]         fa_a_o;
  logic [31:0]         fa_b_o;
  logic                fa_busy_i;
  logic [31:0]         fa_sum_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i, fa_busy_i, fa_sum_i,
    output req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o, fa_start_o, fa_a_o, fa_b_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i, fa_busy_i, fa_sum_i,
    input  req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o, fa_start_o, fa_a_o, fa_b_o
  );
endinterface

// File: rtl/float_adder_arbiter.sv
// Shares one multi-cycle float adder among N_REQ requesters, one operation at a time.
// Define FLOAT_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise lowest index wins.
//
// state       | meaning
// S_IDLE      | waiting for a valid request while the adder is idle; grant issued here
// S_LAUNCH    | one-cycle start pulse to the adder
// S_WAIT_ACK  | waiting for the adder to raise busy
// S_WAIT_DONE | adder busy; sum captured on the first idle cycle
// S_RESP      | response held until the consumer takes it
module float_adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  float_adder_arbiter_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ID_W-1:0]  w_gnt;
  logic [ID_W-1:0]  r_id;
  logic             w_any;
  logic             w_accept;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_sum;
  logic [N_REQ-1:0] w_ready;

`ifdef FLOAT_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;

  // r_ptr is the first index searched: one past the last granted requester
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = ID_W'((int'(r_ptr) + i) % N_REQ);
      if (bus.req_valid_i[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_ptr <= '0;
    else if (w_accept)
      r_ptr <= (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid_i[i]) begin
        w_any = 1'b1;
        w_gnt = ID_W'(i);
      end
    end
  end
`endif

  // A busy adder (e.g. still draining after our reset) blocks new grants
  assign w_accept = (r_state == S_IDLE) && w_any && !bus.fa_busy_i && !rst_i;

  always_comb begin
    w_ready = '0;
    w_a     = '0;
    w_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == w_gnt) begin
        w_a = bus.req_a_i[32*i +: 32];
        w_b = bus.req_b_i[32*i +: 32];
      end
    end
    if (w_accept) w_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_LAUNCH;
      S_LAUNCH:    w_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (bus.fa_busy_i) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!bus.fa_busy_i) w_next = S_RESP;
      S_RESP:      if (bus.rsp_ready_i) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_id  <= '0;
      r_sum <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= w_a;
        r_b  <= w_b;
        r_id <= w_gnt;
      end
      if (r_state == S_WAIT_DONE && !bus.fa_busy_i) r_sum <= bus.fa_sum_i;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.fa_start_o  = (r_state == S_LAUNCH);
  assign bus.fa_a_o      = r_a;
  assign bus.fa_b_o      = r_b;
  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_sum_o   = r_sum;
  assign bus.rsp_id_o    = r_id;
endmodule

// File: tb/tb_float_adder_arbiter.sv
// Self-checking bench for float_adder_arbiter with a behavioural adder stand-in.
module tb_float_adder_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_adder_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();
  float_adder_arbiter #(.N_REQ(N), .ID_W(IW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // Adder stand-in: exact IEEE sums for the directed operand pairs, arbitrary mixing
  // otherwise (the arbiter only moves bits, so any deterministic function will do).
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'hBF800000}: return 32'h40000000;
      {32'h3F800000, 32'hBF800000}: return 32'h00000000;
      {32'h40A00000, 32'h40400000}: return 32'h41000000;
      {32'hC0000000, 32'hC0000000}: return 32'hC0800000;
      default:                      return a + {b[7:0], b[31:8]};
    endcase
  endfunction

  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_sum;
  int          m_lat = 4;
  logic        force_busy = 1'b0;

  assign bus.fa_busy_i = m_busy | force_busy;
  assign bus.fa_sum_i  = m_sum;

  // Sum taken from the operands at the end of the busy window, so unstable operands show up
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_sum  <= '0;
    end else if (bus.fa_start_o) begin
      m_busy <= 1'b1;
      m_cnt  <= m_lat - 1;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_sum  <= fake_add(bus.fa_a_o, bus.fa_b_o);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] sum; } vec_t;
  typedef struct { int id; logic [31:0] sum; } rsp_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] v_tb = '0;
  logic [31:0]  a_tb [N];
  logic [31:0]  b_tb [N];
  logic         rr_tb = 1'b0;

  int   cyc = 0;
  bit   outstanding = 0;
  int   m_ptr = 0;
  rsp_t exp_q [$];
  int   gl [$];
  bit   hs_seen, rsp_seen, prev_rv;
  int   hs_id, hs_cyc, rsp_cyc, rise_cyc;
  int   n_grant = 0, n_start = 0, n_rsp = 0;
  logic [31:0] rsp_sum_cap;
  int   rsp_id_cap;
  logic s_rv;
  logic [31:0] s_sum;
  logic [N-1:0] s_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string detail);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", nm, detail);
  endtask

  function automatic int ref_winner(input logic [N-1:0] v, input int start);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = v >> ((start + i) % N);
      if (t[0]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    bus.req_valid_i = v_tb;
    bus.rsp_ready_i = rr_tb;
    for (int k = 0; k < N; k++) begin
      bus.req_a_i[32*k +: 32] = a_tb[k];
      bus.req_b_i[32*k +: 32] = b_tb[k];
    end
  endtask

  // Reference: one job at a time; grant whenever nothing is outstanding and the adder is idle
  task automatic monitor();
    logic [N-1:0] er;
    logic [N-1:0] hs;
    int w, g;
    rsp_t e;
    hs_seen  = 0;
    rsp_seen = 0;
    s_rv  = bus.rsp_valid_o;
    s_sum = bus.rsp_sum_o;
    s_rdy = bus.req_ready_o;
    if (rst) begin
      outstanding = 0;
      m_ptr = 0;
      exp_q.delete();
      prev_rv = 0;
      chk("ready_in_reset", 64'(bus.req_ready_o), 64'(0));
      return;
    end
    er = '0;
    w  = -1;
    if (!outstanding && !bus.fa_busy_i && v_tb != '0) begin
`ifdef FLOAT_ARB_ROUND_ROBIN_EN
      w = ref_winner(v_tb, m_ptr);
`else
      w = ref_winner(v_tb, 0);
`endif
      er = N'(1) << w;
    end
    chk("req_ready", 64'(bus.req_ready_o), 64'(er));
    if (bus.fa_start_o) n_start++;
    hs = bus.req_ready_o & v_tb;
    if (hs != '0) begin
      g = ref_winner(hs, 0);
      hs_seen = 1;
      hs_id   = g;
      hs_cyc  = cyc;
      gl.push_back(g);
      exp_q.push_back('{g, fake_add(a_tb[g], b_tb[g])});
      outstanding = 1;
      m_ptr = (g + 1) % N;
      n_grant++;
    end
    if (bus.rsp_valid_o && !prev_rv) rise_cyc = cyc;
    prev_rv = bus.rsp_valid_o;
    if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      rsp_seen    = 1;
      rsp_cyc     = cyc;
      rsp_sum_cap = bus.rsp_sum_o;
      rsp_id_cap  = int'(bus.rsp_id_o);
      n_rsp++;
      outstanding = 0;
      if (exp_q.size() == 0) begin
        fail_now("rsp_unexpected", $sformatf("got id %0d sum %h, required no response",
                 bus.rsp_id_o, bus.rsp_sum_o));
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'(bus.rsp_id_o), 64'(e.id));
        chk("rsp_sum", 64'(bus.rsp_sum_o), 64'(e.sum));
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_hs(input int id, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (hs_seen && hs_id == id) ok = 1;
    end
    if (!ok) fail_now("grant_timeout", $sformatf("got no grant to %0d, required one within %0d cycles", id, limit));
  endtask

  task automatic wait_rsp(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (rsp_seen) ok = 1;
    end
    if (!ok) fail_now("rsp_timeout", $sformatf("got no response, required one within %0d cycles", limit));
  endtask

  task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b,
                        output bit ok, output int lat, output int starts);
    int st0;
    a_tb[id] = a;
    b_tb[id] = b;
    v_tb[id] = 1'b1;
    st0 = n_start;
    lat = -1;
    wait_hs(id, 40, ok);
    v_tb[id] = 1'b0;
    if (ok) begin
      wait_rsp(60, ok);
      lat = rise_cyc - hs_cyc;
    end
    starts = n_start - st0;
  endtask

  vec_t vt [5];
`ifdef FLOAT_ARB_ROUND_ROBIN_EN
  localparam int N_ORD = 5;
  int exp_order [5] = '{0, 1, 2, 3, 0};
`else
  localparam int N_ORD = 3;
  int exp_order [5] = '{0, 0, 0, 0, 0};
`endif

  initial begin
    bit ok;
    int lat, starts, n0, g2;
    vt[0] = '{1, 32'h3F800000, 32'h40000000, 32'h40400000};
    vt[1] = '{0, 32'h40400000, 32'hBF800000, 32'h40000000};
    vt[2] = '{3, 32'h3F800000, 32'hBF800000, 32'h00000000};
    vt[3] = '{2, 32'h40A00000, 32'h40400000, 32'h41000000};
    vt[4] = '{1, 32'hC0000000, 32'hC0000000, 32'hC0800000};
    for (int k = 0; k < N; k++) begin
      a_tb[k] = 32'h11111111 * (k + 1);
      b_tb[k] = 32'h01010101 * (k + 3);
    end

    // reset values
    tick();
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("rst_rsp_sum", 64'(bus.rsp_sum_o), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id_o), 64'(0));
    chk("rst_fa_start", 64'(bus.fa_start_o), 64'(0));
    chk("rst_fa_a", 64'(bus.fa_a_o), 64'(0));
    chk("rst_fa_b", 64'(bus.fa_b_o), 64'(0));
    tick();
    rst = 1'b0;

    // all requesters valid continuously
    rr_tb = 1'b1;
    v_tb  = '1;
    gl.delete();
    for (int i = 0; i < 100 && gl.size() < N_ORD; i++) tick();
    v_tb = '0;
    if (gl.size() < N_ORD) fail_now("arb_order_timeout", $sformatf("got %0d grants, required %0d", gl.size(), N_ORD));
    else for (int i = 0; i < N_ORD; i++) chk($sformatf("arb_order[%0d]", i), 64'(gl[i]), 64'(exp_order[i]));
    for (int i = 0; i < 40 && outstanding; i++) tick();

    // table-driven single requests
    for (int i = 0; i < 5; i++) begin
      do_req(vt[i].id, vt[i].a, vt[i].b, ok, lat, starts);
      if (ok) begin
        chk($sformatf("vec%0d_sum", i), 64'(rsp_sum_cap), 64'(vt[i].sum));
        chk($sformatf("vec%0d_id", i), 64'(rsp_id_cap), 64'(vt[i].id));
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(7));
        chk($sformatf("vec%0d_starts", i), 64'(starts), 64'(1));
      end
      tick();
    end

    // response stall with another requester waiting
    rr_tb = 1'b0;
    a_tb[1] = 32'h3F800000; b_tb[1] = 32'h40000000; v_tb[1] = 1'b1;
    wait_hs(1, 40, ok);
    v_tb[1] = 1'b0;
    a_tb[2] = 32'h40A00000; b_tb[2] = 32'h40400000; v_tb[2] = 1'b1;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = s_rv; end
    if (!ok) fail_now("stall_rsp_timeout", "got no rsp_valid, required one within 30 cycles");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_valid", 64'(s_rv), 64'(1));
      chk("stall_sum", 64'(s_sum), 64'(32'h40400000));
      chk("stall_ready", 64'(s_rdy), 64'(0));
    end
    rr_tb = 1'b1;
    tick();
    chk("stall_rsp_hs", 64'(rsp_seen), 64'(1));
    n0 = rsp_cyc;
    wait_hs(2, 5, ok);
    if (ok) chk("grant_after_rsp_gap", 64'(hs_cyc - n0), 64'(1));
    v_tb[2] = 1'b0;
    wait_rsp(30, ok);
    if (ok) chk("stall_next_sum", 64'(rsp_sum_cap), 64'(32'h41000000));

    // requester 2 withdraws while requester 0 is served
    g2 = 0;
    foreach (gl[i]) if (gl[i] == 2) g2++;
    a_tb[0] = 32'h40400000; b_tb[0] = 32'hBF800000; v_tb[0] = 1'b1;
    wait_hs(0, 20, ok);
    v_tb[0] = 1'b0;
    v_tb[2] = 1'b1;
    tick(); tick(); tick();
    v_tb[2] = 1'b0;
    wait_rsp(30, ok);
    for (int i = 0; i < 5; i++) tick();
    n0 = 0;
    foreach (gl[i]) if (gl[i] == 2) n0++;
    chk("withdrawn_not_granted", 64'(n0 - g2), 64'(0));

    // adder busy while idle blocks grants
    force_busy = 1'b1;
    v_tb[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("busy_idle_ready", 64'(s_rdy), 64'(0));
    end
    force_busy = 1'b0;
    wait_hs(1, 3, ok);
    v_tb[1] = 1'b0;
    wait_rsp(30, ok);

    // reset during WAIT_DONE
    a_tb[0] = 32'h3F800000; b_tb[0] = 32'h40000000; v_tb[0] = 1'b1;
    wait_hs(0, 20, ok);
    v_tb[0] = 1'b0;
    v_tb[3] = 1'b1;
    drive();
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("arst_rsp_sum", 64'(bus.rsp_sum_o), 64'(0));
    chk("arst_rsp_id", 64'(bus.rsp_id_o), 64'(0));
    chk("arst_fa_start", 64'(bus.fa_start_o), 64'(0));
    chk("arst_fa_a", 64'(bus.fa_a_o), 64'(0));
    chk("arst_fa_b", 64'(bus.fa_b_o), 64'(0));
    chk("arst_ready", 64'(bus.req_ready_o), 64'(0));
    v_tb[3] = 1'b0;
    tick();
    rst = 1'b0;
    n0 = n_rsp;
    for (int i = 0; i < 15; i++) tick();
    chk("no_rsp_after_reset", 64'(n_rsp - n0), 64'(0));
    do_req(2, 32'h40A00000, 32'h40400000, ok, lat, starts);
    if (ok) begin
      chk("post_reset_sum", 64'(rsp_sum_cap), 64'(32'h41000000));
      chk("post_reset_id", 64'(rsp_id_cap), 64'(2));
    end

    // randomized traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      rr_tb = ($urandom % 4) != 0;
      m_lat = $urandom_range(4, 7);
      for (int k = 0; k < N; k++) begin
        if (v_tb[k]) begin
          if ($urandom % 10 == 0) v_tb[k] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          v_tb[k] = 1'b1;
          a_tb[k] = $urandom;
          b_tb[k] = $urandom;
        end
      end
      tick();
      if (hs_seen) v_tb[hs_id] = 1'b0;
    end
    v_tb  = '0;
    rr_tb = 1'b1;
    for (int i = 0; i < 60 && (outstanding || exp_q.size() != 0); i++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("start_count", 64'(n_start), 64'(n_grant));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/float_adder_arbiter.md
# float_adder_arbiter

Shares one multi-cycle `float_adder_ff` instance between `N_REQ` requesters. Each requester offers an operand pair through a valid/ready handshake. The block grants one request at a time, launches the adder with a one-cycle start pulse, and tracks the adder's `busy_o` to find completion. It then returns the 32-bit sum on a single response channel, tagged with the requester index. It sits between the requester fabric and the adder and is the only driver of the adder's `start_i`, `in_a` and `in_b`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  N_REQ  per-requester request valid.
- `req_ready_o`  out  N_REQ  per-requester accept strobe; one-hot or zero.
- `req_a_i`  in  32*N_REQ  operand A; requester k uses bits [32k+31:32k].
- `req_b_i`  in  32*N_REQ  operand B; same packing as A.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_sum_o`  out  32  IEEE-754 single-precision sum.
- `rsp_id_o`  out  ID_W  index of the requester that owns the response.
- `fa_start_o`  out  1  drives adder `start_i`.
- `fa_a_o`, `fa_b_o`  out  32 each  drive adder `in_a` and `in_b`.
- `fa_busy_i`  in  1  from adder `busy_o`.
- `fa_sum_i`  in  32  from adder `out_sum`.

## Operation
State machine: IDLE → LAUNCH → WAIT_ACK → WAIT_DONE → RESP → IDLE.
- **IDLE**
  - If any `req_valid_i` bit is set, select grant g (selection rule under Configuration).
  - Assert `req_ready_o[g]` combinationally in this cycle; the handshake completes when valid and ready are both high.
  - Latch operands into `fa_a_o`/`fa_b_o` and g into the id register.
  - Go to LAUNCH.
- **LAUNCH**
  - `fa_start_o`=1 for exactly this cycle; operands stay stable.
  - Go to WAIT_ACK.
- **WAIT_ACK**
  - Stay until `fa_busy_i`=1, then go to WAIT_DONE.
  - Operands held stable throughout.
- **WAIT_DONE**
  - Stay while `fa_busy_i`=1.
  - On the first cycle with `fa_busy_i`=0, register `fa_sum_i` into `rsp_sum_o` and go to RESP.
- **RESP**
  - `rsp_valid_o`=1, with `rsp_sum_o`/`rsp_id_o` stable, until `rsp_ready_i`=1.
  - Go to IDLE on that handshake.

Outstanding work and arithmetic:
- Exactly one operation is outstanding at a time. No grant is issued in any state other than IDLE.
- No arithmetic is done in this block; operand and result bits pass through unmodified.

Boundary conditions:
- A requester that deasserts valid before being granted is simply not granted.
- `req_ready_o` is zero in every state except IDLE.
- `rsp_ready_i` held low stalls the block in RESP indefinitely. All requests wait, and the response is never overwritten.
- `fa_busy_i` already high in IDLE: no launch. The block stays in IDLE with `req_ready_o`=0 until the adder is idle.
- Reset asserted in any state:
  - Block returns to IDLE immediately.
  - An in-flight request is dropped and no response is produced.
  - The adder must share `rst_i`.

## Timing
Reset values:
- `req_ready_o`=0, `rsp_valid_o`=0, `rsp_sum_o`=0, `rsp_id_o`=0.
- `fa_start_o`=0, `fa_a_o`=0, `fa_b_o`=0.
- Grant pointer = 0.

Latency:
- Accept at cycle T, `fa_start_o` at T+1, `fa_busy_i` high from T+2.
- The adder stays busy for at least 4 cycles (more when a left normalization is needed).
- If busy falls at cycle D, `rsp_valid_o` rises at D+1.
- Minimum accept-to-response latency is 7 cycles with back-to-back `rsp_ready_i`=1.
- After the response handshake at cycle R, the next grant can occur at R+1.

## Configuration
Macro `FLOAT_ARB_ROUND_ROBIN_EN`:
- **Defined:** round-robin arbitration.
  - Search starts at index (last_grant+1) mod N_REQ, wrapping past N_REQ-1 to 0.
  - The pointer updates only on a completed request handshake.
- **Undefined:** fixed priority. The lowest-index valid requester always wins, and the pointer register is not instantiated.

## Test plan
- Single request, id 1: A=0x3F800000 (1.0), B=0x40000000 (2.0), `rsp_ready_i`=1 → `rsp_sum_o`=0x40400000, `rsp_id_o`=1, `rsp_valid_o` 7 cycles after accept.
- Opposite signs: A=0x40400000 (3.0), B=0xBF800000 (−1.0) → 0x40000000 (2.0), exactly one `fa_start_o` pulse.
- All 4 requesters valid continuously, round-robin defined → grants 0,1,2,3,0 in order. With the macro undefined → grants 0,0,0.
- `rsp_ready_i` held low 20 cycles with another requester valid → `rsp_valid_o` and sum held stable, `req_ready_o`=0 throughout; next grant one cycle after the handshake.
- `rst_i` pulsed during WAIT_DONE → all outputs return to reset values asynchronously, no response is issued, and a new request afterwards completes normally.
- Requester 2 drops valid while requester 0 is being served → requester 2 is never granted, and no stray `req_ready_o[2]` occurs.
